// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshake and embedded-memory port bundle for mem_lsu.
`ifndef MEM_BYT_8_U
`define MEM_BYT_8_U 8'hFF
`endif

interface mem_lsu_if #(parameter int DATA_WIDTH = 64);
    logic                  iReqValid;
    logic                  oReqReady;
    logic                  iReqWr;
    logic [1:0]            iReqSize;
    logic                  iReqSigned;
    logic [DATA_WIDTH-1:0] iReqAddr;
    logic [DATA_WIDTH-1:0] iReqData;
    logic                  oRspValid;
    logic                  iRspReady;
    logic [DATA_WIDTH-1:0] oRspData;
    logic                  oRspErr;
    logic                  oMemRdEn;
    logic                  oMemWrEn;
    logic [DATA_WIDTH-1:0] oMemAddr;
    logic [DATA_WIDTH-1:0] oMemWrData;
    logic [DATA_WIDTH-1:0] oMemWrByt;
    logic [DATA_WIDTH-1:0] iMemRdData;

    modport slave (
        input  iReqValid, iReqWr, iReqSize, iReqSigned, iReqAddr, iReqData, iRspReady, iMemRdData,
        output oReqReady, oRspValid, oRspData, oRspErr, oMemRdEn, oMemWrEn, oMemAddr, oMemWrData, oMemWrByt
    );

    modport master (
        output iReqValid, iReqWr, iReqSize, iReqSigned, iReqAddr, iReqData, iRspReady, iMemRdData,
        input  oReqReady, oRspValid, oRspData, oRspErr, oMemRdEn, oMemWrEn, oMemAddr, oMemWrData, oMemWrByt
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit with read-modify-write for sub-word stores.
module mem_lsu #(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] ADDR_BASE  = 64'h8000_0000
) (
    input logic       iClock,
    input logic       iReset,
    mem_lsu_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d, sgn_q, sgn_d, err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic                  accept, req_err;
    logic [2:0]            align_m;
    logic [5:0]            sh;
    logic [31:0]           lane;
    logic [DATA_WIDTH-1:0] lane_m, ext, merged;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        accept  = bus.iReqValid && state_q == IDLE;
        align_m = bus.iReqSize == 2'd0 ? 3'd0 : bus.iReqSize == 2'd1 ? 3'd1 : bus.iReqSize == 2'd2 ? 3'd3 : 3'd7;
        req_err = |(bus.iReqAddr[2:0] & align_m) || bus.iReqAddr < ADDR_BASE;
        wr_d    = accept ? bus.iReqWr : wr_q;
        sgn_d   = accept ? bus.iReqSigned : sgn_q;
        err_d   = accept ? req_err : err_q;
        size_d  = accept ? bus.iReqSize : size_q;
        addr_d  = accept ? bus.iReqAddr : addr_q;
        data_d  = accept ? bus.iReqData : data_q;
        rdata_d = state_q == CAP ? bus.iMemRdData : rdata_q;
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : (bus.iReqWr && bus.iReqSize == 2'd3) ? WR : RD;
            RD:      state_d = CAP;
            CAP:     state_d = wr_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (bus.iRspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and byte-lane merge for read-modify-write stores.
    always_comb begin
        sh     = {addr_q[2:0], 3'b000};
        lane   = 32'(rdata_q >> sh);
        lane_m = size_q == 2'd0 ? DATA_WIDTH'(8'hFF) : size_q == 2'd1 ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(32'hFFFF_FFFF);
        ext    = size_q == 2'd3 ? rdata_q :
                 size_q == 2'd0 ? {{(DATA_WIDTH-8){sgn_q & lane[7]}}, lane[7:0]} :
                 size_q == 2'd1 ? {{(DATA_WIDTH-16){sgn_q & lane[15]}}, lane[15:0]} :
                                  {{(DATA_WIDTH-32){sgn_q & lane[31]}}, lane};
        merged = size_q == 2'd3 ? data_q : (rdata_q & ~(lane_m << sh)) | ((data_q & lane_m) << sh);
    end

    always_comb begin
        bus.oReqReady  = state_q == IDLE;
        bus.oRspValid  = state_q == RESP;
        bus.oRspErr    = state_q == RESP && err_q;
        bus.oRspData   = (state_q == RESP && !err_q && !wr_q) ? ext : '0;
        bus.oMemRdEn   = state_q == RD;
        bus.oMemWrEn   = state_q == WR;
        bus.oMemAddr   = (state_q == RD || state_q == WR) ? {addr_q[DATA_WIDTH-1:3], 3'b000} : '0;
        bus.oMemWrData = state_q == WR ? merged : '0;
        bus.oMemWrByt  = state_q == WR ? DATA_WIDTH'(`MEM_BYT_8_U) : '0;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven load/store vectors plus stall and mid-write reset sequences.
module tb_mem_lsu;
    logic iClock = 1'b0;
    logic iReset = 1'b1;
    always #5 iClock = ~iClock;

    mem_lsu_if #(.DATA_WIDTH(64)) bus ();
    mem_lsu #(.DATA_WIDTH(64), .ADDR_BASE(64'h8000_0000)) dut (.iClock(iClock), .iReset(iReset), .bus(bus));

    logic [63:0] mem [16];
    int          rd_tot = 0, wr_tot = 0;
    logic [63:0] last_wd = '0, last_wb = '0;

    // Memory model: read data appears the cycle after oMemRdEn.
    always @(posedge iClock) begin
        if (iReset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
            mem[1] <= 64'h1122334455667788;
            mem[2] <= 64'h8899AABBCCDDEEFF;
            mem[3] <= 64'h0123456789ABCDEF;
            bus.iMemRdData <= '0;
        end else begin
            if (bus.oMemRdEn) begin
                bus.iMemRdData <= mem[bus.oMemAddr[6:3]];
                rd_tot <= rd_tot + 1;
            end
            if (bus.oMemWrEn) begin
                mem[bus.oMemAddr[6:3]] <= bus.oMemWrData;
                wr_tot  <= wr_tot + 1;
                last_wd <= bus.oMemWrData;
                last_wb <= bus.oMemWrByt;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [63:0] exp_wd;
    } vec_t;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input int k);
        int lat, rd0, wr0;
        @(negedge iClock);
        bus.iReqWr = t.wr; bus.iReqSize = t.size; bus.iReqSigned = t.sgn;
        bus.iReqAddr = t.addr; bus.iReqData = t.data; bus.iReqValid = 1'b1;
        rd0 = rd_tot; wr0 = wr_tot;
        @(posedge iClock);
        @(negedge iClock);
        bus.iReqValid = 1'b0;
        lat = 1;
        while (!bus.oRspValid && lat < 20) begin
            @(negedge iClock);
            lat++;
        end
        chk($sformatf("v%0d latency", k), 64'(lat), 64'(t.exp_lat));
        chk($sformatf("v%0d rsp_data", k), bus.oRspData, t.exp_data);
        chk($sformatf("v%0d rsp_err", k), 64'(bus.oRspErr), 64'(t.exp_err));
        chk($sformatf("v%0d rd_pulses", k), 64'(rd_tot - rd0), 64'(t.exp_rd));
        chk($sformatf("v%0d wr_pulses", k), 64'(wr_tot - wr0), 64'(t.exp_wr));
        if (t.exp_wr != 0) begin
            chk($sformatf("v%0d wr_data", k), last_wd, t.exp_wd);
            chk($sformatf("v%0d wr_byt", k), last_wb, 64'hFF);
        end
        bus.iRspReady = 1'b1;
        @(negedge iClock);
        bus.iRspReady = 1'b0;
        chk($sformatf("v%0d ready_after", k), 64'(bus.oReqReady), 64'd1);
        chk($sformatf("v%0d valid_after", k), 64'(bus.oRspValid), 64'd0);
    endtask

    vec_t v [18];

    initial begin
        int lat, rd0, wr0;
        v[0]  = '{1'b0, 2'd0, 1'b1, 64'h8000_0008, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 3, 1, 0, 64'h0};
        v[1]  = '{1'b0, 2'd0, 1'b0, 64'h8000_0008, 64'h0, 64'h88, 1'b0, 3, 1, 0, 64'h0};
        v[2]  = '{1'b0, 2'd1, 1'b1, 64'h8000_0012, 64'h0, 64'hFFFF_FFFF_FFFF_CCDD, 1'b0, 3, 1, 0, 64'h0};
        v[3]  = '{1'b0, 2'd2, 1'b1, 64'h8000_0014, 64'h0, 64'hFFFF_FFFF_8899_AABB, 1'b0, 3, 1, 0, 64'h0};
        v[4]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'h0, 64'hCCDD_EEFF, 1'b0, 3, 1, 0, 64'h0};
        v[5]  = '{1'b0, 2'd3, 1'b1, 64'h8000_0010, 64'h0, 64'h8899_AABB_CCDD_EEFF, 1'b0, 3, 1, 0, 64'h0};
        v[6]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 64'h0, 1'b1, 1, 0, 0, 64'h0};
        v[7]  = '{1'b0, 2'd3, 1'b0, 64'h7FFF_FFF8, 64'h0, 64'h0, 1'b1, 1, 0, 0, 64'h0};
        v[8]  = '{1'b1, 2'd1, 1'b0, 64'h8000_0009, 64'hABCD, 64'h0, 1'b1, 1, 0, 0, 64'h0};
        v[9]  = '{1'b1, 2'd1, 1'b0, 64'h8000_000A, 64'hABCD, 64'h0, 1'b0, 4, 1, 1, 64'h1122_3344_ABCD_7788};
        v[10] = '{1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 64'h1122_3344_ABCD_7788, 1'b0, 3, 1, 0, 64'h0};
        v[11] = '{1'b1, 2'd0, 1'b0, 64'h8000_000F, 64'h1234_5699, 64'h0, 1'b0, 4, 1, 1, 64'h9922_3344_ABCD_7788};
        v[12] = '{1'b0, 2'd0, 1'b1, 64'h8000_000F, 64'h0, 64'hFFFF_FFFF_FFFF_FF99, 1'b0, 3, 1, 0, 64'h0};
        v[13] = '{1'b1, 2'd3, 1'b0, 64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 2, 0, 1, 64'hDEAD_BEEF_CAFE_F00D};
        v[14] = '{1'b1, 2'd2, 1'b0, 64'h8000_0014, 64'hFFFF_FFFF_0102_0304, 64'h0, 1'b0, 4, 1, 1, 64'h0102_0304_CCDD_EEFF};
        v[15] = '{1'b0, 2'd2, 1'b0, 64'h8000_0014, 64'h0, 64'h0102_0304, 1'b0, 3, 1, 0, 64'h0};
        v[16] = '{1'b0, 2'd1, 1'b0, 64'h8000_000C, 64'h0, 64'h3344, 1'b0, 3, 1, 0, 64'h0};
        v[17] = '{1'b1, 2'd0, 1'b0, 64'h7FFF_FFFF, 64'h55, 64'h0, 1'b1, 1, 0, 0, 64'h0};

        bus.iReqValid = 1'b0; bus.iReqWr = 1'b0; bus.iReqSize = 2'd0; bus.iReqSigned = 1'b0;
        bus.iReqAddr = '0; bus.iReqData = '0; bus.iRspReady = 1'b0;

        repeat (2) @(negedge iClock);
        chk("rst ready", 64'(bus.oReqReady), 64'd1);
        chk("rst rsp_valid", 64'(bus.oRspValid), 64'd0);
        chk("rst rsp_err", 64'(bus.oRspErr), 64'd0);
        chk("rst rd_en", 64'(bus.oMemRdEn), 64'd0);
        chk("rst wr_en", 64'(bus.oMemWrEn), 64'd0);
        chk("rst rsp_data", bus.oRspData, 64'h0);
        chk("rst mem_addr", bus.oMemAddr, 64'h0);
        chk("rst wr_data", bus.oMemWrData, 64'h0);
        chk("rst wr_byt", bus.oMemWrByt, 64'h0);
        iReset = 1'b0;

        for (int i = 0; i < 18; i++) run(v[i], i);

        // Response held under back-pressure while stray requests are ignored.
        @(negedge iClock);
        bus.iReqWr = 1'b0; bus.iReqSize = 2'd3; bus.iReqSigned = 1'b0;
        bus.iReqAddr = 64'h8000_0018; bus.iReqValid = 1'b1;
        @(posedge iClock);
        @(negedge iClock);
        bus.iReqValid = 1'b0;
        lat = 1;
        while (!bus.oRspValid && lat < 20) begin
            @(negedge iClock);
            lat++;
        end
        chk("stall latency", 64'(lat), 64'd3);
        rd0 = rd_tot; wr0 = wr_tot;
        bus.iReqWr = 1'b1; bus.iReqSize = 2'd3; bus.iReqAddr = 64'h8000_0008; bus.iReqData = 64'h5A5A;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall%0d valid", i), 64'(bus.oRspValid), 64'd1);
            chk($sformatf("stall%0d data", i), bus.oRspData, 64'hDEAD_BEEF_CAFE_F00D);
            chk($sformatf("stall%0d err", i), 64'(bus.oRspErr), 64'd0);
            chk($sformatf("stall%0d ready", i), 64'(bus.oReqReady), 64'd0);
            bus.iReqValid = (i < 5) ? ~i[0] : 1'b0;
            bus.iRspReady = (i == 5);
            @(negedge iClock);
        end
        bus.iRspReady = 1'b0;
        chk("stall idle ready", 64'(bus.oReqReady), 64'd1);
        chk("stall idle valid", 64'(bus.oRspValid), 64'd0);
        repeat (3) @(negedge iClock);
        chk("stall no access", 64'(rd_tot - rd0 + wr_tot - wr0), 64'd0);
        chk("stall still idle", 64'(bus.oRspValid), 64'd0);

        // Asynchronous reset while the write strobe is up abandons the store.
        bus.iReqWr = 1'b1; bus.iReqSize = 2'd3; bus.iReqAddr = 64'h8000_0020;
        bus.iReqData = 64'h0BAD_0BAD; bus.iReqValid = 1'b1;
        wr0 = wr_tot;
        @(posedge iClock);
        @(negedge iClock);
        bus.iReqValid = 1'b0;
        chk("rstwr wr_en before", 64'(bus.oMemWrEn), 64'd1);
        #2 iReset = 1'b1;
        #1;
        chk("rstwr wr_en", 64'(bus.oMemWrEn), 64'd0);
        chk("rstwr ready", 64'(bus.oReqReady), 64'd1);
        chk("rstwr rsp_valid", 64'(bus.oRspValid), 64'd0);
        chk("rstwr mem_addr", bus.oMemAddr, 64'h0);
        chk("rstwr wr_data", bus.oMemWrData, 64'h0);
        repeat (2) @(negedge iClock);
        iReset = 1'b0;
        repeat (3) @(negedge iClock);
        chk("rstwr no rsp", 64'(bus.oRspValid), 64'd0);
        chk("rstwr no write", 64'(wr_tot - wr0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data and address width in bits.
REQ-002 SHALL have parameter ADDR_BASE, default 64'h8000_0000, lowest legal memory byte address.
REQ-003 SHALL have port iClock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port iReset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port iReqValid  in  1  request valid.
REQ-006 SHALL have port oReqReady  out  1  request ready.
REQ-007 SHALL have port iReqWr  in  1  1 = store, 0 = load.
REQ-008 SHALL have port iReqSize  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 SHALL have port iReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have port iReqAddr  in  DATA_WIDTH  byte address.
REQ-011 SHALL have port iReqData  in  DATA_WIDTH  store data, right-aligned.
REQ-012 SHALL have port oRspValid  out  1  response valid.
REQ-013 SHALL have port iRspReady  in  1  response ready.
REQ-014 SHALL have port oRspData  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-015 SHALL have port oRspErr  out  1  misaligned access, or address below ADDR_BASE.
REQ-016 SHALL have ports oMemRdEn  out  1, oMemWrEn  out  1, oMemAddr  out  DATA_WIDTH, oMemWrData  out  DATA_WIDTH, oMemWrByt  out  DATA_WIDTH: drive the embedded memory port.
REQ-017 SHALL have port iMemRdData  in  DATA_WIDTH  memory read data, valid the cycle after oMemRdEn.

Function
REQ-018 SHALL implement states IDLE, RD, CAP, WR, RESP; oReqReady = 1 only in IDLE.
REQ-019 SHALL latch wr, size, signed, addr and data when iReqValid && oReqReady.
REQ-020 SHALL flag an error when the address is misaligned (addr mod 2^size != 0) or the address is below ADDR_BASE; an error request SHALL go IDLE->RESP with oRspErr = 1 and oRspData = 0, with no memory access.
REQ-021 SHALL drive oMemAddr = {addr[63:3], 3'b000} in RD and WR, and 0 in every other state.
REQ-022 Loads SHALL follow IDLE->RD->CAP->RESP.
REQ-023 In RD, oMemRdEn SHALL be 1 for exactly one cycle.
REQ-024 In CAP, iMemRdData SHALL be registered.
REQ-025 oRspData SHALL be the lane at byte offset addr[2:0], extended per iReqSigned to 64 bits; size 3 SHALL return the word unchanged.
REQ-026 Double stores SHALL follow IDLE->WR->RESP.
REQ-027 Sub-word stores SHALL follow IDLE->RD->CAP->WR->RESP (read-modify-write).
REQ-028 For a sub-word store, only bytes addr[2:0] .. addr[2:0]+2^size-1 SHALL be replaced with the low bytes of the data; all other bytes SHALL be kept.
REQ-029 In WR, oMemWrEn SHALL be 1 for exactly one cycle, oMemWrData SHALL be the merged (or full) word, and oMemWrByt SHALL be `MEM_BYT_8_U.
REQ-030 oMemRdEn and oMemWrEn SHALL never both be 1.
REQ-031 Both SHALL be decoded from the state register only.
REQ-032 Latency from accept edge to oRspValid SHALL be: 3 cycles for a load, 2 for a double store, 4 for a sub-word store, 1 for an error.
REQ-033 RESP SHALL hold oRspValid, oRspData and oRspErr stable until iRspReady = 1.
REQ-034 The state SHALL return to IDLE on the edge where oRspValid && iRspReady.
REQ-035 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-036 iReqValid outside IDLE SHALL be ignored.

Reset
REQ-037 iReset = 1 SHALL immediately force IDLE.
REQ-038 During reset, oReqReady SHALL be 1, and oRspValid, oRspErr, oMemRdEn and oMemWrEn SHALL be 0.
REQ-039 During reset, oRspData, oMemAddr, oMemWrData and oMemWrByt SHALL be 0, and all latched request fields SHALL be cleared.
REQ-040 Reset during RD, CAP or WR SHALL abandon the operation: no further memory strobe and no response.

Verification
REQ-041 Memory word at 0x8000_0008 = 0x1122334455667788; signed byte load at 0x8000_0008 -> oRspData = 0xFFFF_FFFF_FFFF_FF88, err 0, oRspValid 3 cycles after accept; unsigned -> 0x88.
REQ-042 Same word; half store at 0x8000_000A with data 0xABCD -> RD, CAP, WR sequence, oMemWrData = 0x11223344ABCD7788, oMemWrByt = `MEM_BYT_8_U, response 4 cycles after accept.
REQ-043 Word load at 0x8000_0002 -> oRspErr = 1, oRspData = 0, oRspValid 1 cycle after accept, no RdEn/WrEn pulse; load at 0x7FFF_FFF8 -> same.
REQ-044 Double load completes with iRspReady held 0 for 5 cycles -> response stable for all 6 cycles; oReqReady 0 throughout; iReqValid pulses ignored.
REQ-045 iReset asserted mid-cycle while in WR -> oMemWrEn falls without waiting for a clock edge, state IDLE, oReqReady 1, no response issued.
